// File: rtl/vending_param_moore.sv
// Parametrised Moore vending controller: credits N/D/Q coins, vends at PRICE,
// and returns leftover credit greedily as one coin per cycle.
module vending_param_moore #(
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 100,
  parameter int CREDIT_W   = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                cancel,
  output logic                P,
  output logic                C,
  output logic                change_q,
  output logic                change_d,
  output logic                change_n,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_t;

  localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] V25   = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] V10   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] V5    = CREDIT_W'(5);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                rej_q, rej_d;

  logic                coin_any;
  logic                coin_multi;
  logic [CREDIT_W:0]   coin_v;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] step;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      rej_q    <= rej_d;
    end
  end

  assign coin_any   = N | D | Q;
  assign coin_multi = (N & D) | (N & Q) | (D & Q);

  always_comb begin
    coin_v = '0;
    case ({N, D, Q})
      3'b100:  coin_v = (CREDIT_W+1)'(5);
      3'b010:  coin_v = (CREDIT_W+1)'(10);
      3'b001:  coin_v = (CREDIT_W+1)'(25);
      default: coin_v = '0;
    endcase
  end

  // Wide sum so an overflowing coin is caught before the register wraps.
  assign sum = {1'b0, credit_q} + coin_v;

  always_comb begin
    step = V5;
    if (change_q) step = V25;
    else if (change_d) step = V10;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rej_d    = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (state_q == COLLECT && cancel) begin
          state_d = CHANGE;
          rej_d   = coin_any;
        end else if (coin_multi) begin
          rej_d = 1'b1;
        end else if (coin_any) begin
          if (sum > MAX_W) begin
            rej_d = 1'b1;
          end else if (sum < PRICE_W) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            credit_d = CREDIT_W'(sum - PRICE_W);
            state_d  = VEND;
          end
        end
      end
      VEND: begin
        rej_d   = coin_any;
        state_d = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_d = coin_any;
        if (credit_q <= step) begin
          credit_d = '0;
          state_d  = IDLE;
        end else begin
          credit_d = credit_q - step;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_comb begin
    P        = (state_q == VEND);
    C        = (state_q == CHANGE);
    change_q = C && (credit_q >= V25);
    change_d = C && (credit_q < V25) && (credit_q >= V10);
    change_n = C && (credit_q < V10);
    coin_rej = rej_q;
    credit   = credit_q;
  end

endmodule

// File: tb/tb_vending_param_moore.sv
// Bench for vending_param_moore: directed steps plus random coins checked
// against a coin-queue reference model.
module tb_vending_param_moore;

  localparam int PRICE = 25;
  localparam int MAXC  = 100;

  logic clock = 1'b0;
  logic reset;
  logic N, D, Q, cancel;
  logic P, C, change_q, change_d, change_n, coin_rej;
  logic [7:0] credit;

  logic N2, D2, Q2, cancel2;
  logic P2, C2, cq2, cd2, cn2, rej2;
  logic [7:0] credit2;

  int errors = 0;
  int checks = 0;

  int m_credit;
  bit m_vend;
  bit m_rej;
  int m_q[$];

  vending_param_moore #(.PRICE(25), .MAX_CREDIT(100), .CREDIT_W(8)) dut (
    .clock(clock), .reset(reset), .N(N), .D(D), .Q(Q), .cancel(cancel),
    .P(P), .C(C), .change_q(change_q), .change_d(change_d),
    .change_n(change_n), .coin_rej(coin_rej), .credit(credit)
  );

  vending_param_moore #(.PRICE(25), .MAX_CREDIT(30), .CREDIT_W(8)) dut2 (
    .clock(clock), .reset(reset), .N(N2), .D(D2), .Q(Q2), .cancel(cancel2),
    .P(P2), .C(C2), .change_q(cq2), .change_d(cd2),
    .change_n(cn2), .coin_rej(rej2), .credit(credit2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void greedy(input int amt);
    int a;
    a = amt;
    m_q.delete();
    while (a > 0) begin
      if (a >= 25) begin m_q.push_back(25); a -= 25; end
      else if (a >= 10) begin m_q.push_back(10); a -= 10; end
      else begin m_q.push_back(5); a -= 5; end
    end
  endfunction

  function automatic void model_reset();
    m_credit = 0;
    m_vend   = 0;
    m_rej    = 0;
    m_q.delete();
  endfunction

  function automatic void model_step(input bit n, d, q, c);
    int nc;
    int v;
    nc = int'(n) + int'(d) + int'(q);
    m_rej = 0;
    if (m_vend) begin
      m_vend = 0;
      m_rej  = (nc > 0);
      if (m_credit > 0) greedy(m_credit);
    end else if (m_q.size() > 0) begin
      m_rej = (nc > 0);
      m_credit -= m_q.pop_front();
    end else if (c && m_credit > 0) begin
      m_rej = (nc > 0);
      greedy(m_credit);
    end else if (nc > 1) begin
      m_rej = 1;
    end else if (nc == 1) begin
      v = n ? 5 : (d ? 10 : 25);
      if (m_credit + v > MAXC) m_rej = 1;
      else if (m_credit + v < PRICE) m_credit += v;
      else begin
        m_credit += v - PRICE;
        m_vend = 1;
      end
    end
  endfunction

  task automatic check_model();
    bit busy;
    int f;
    busy = (m_q.size() > 0);
    f = busy ? m_q[0] : 0;
    chk("P", 32'(P), 32'(m_vend));
    chk("C", 32'(C), 32'(busy));
    chk("change_q", 32'(change_q), 32'(f == 25));
    chk("change_d", 32'(change_d), 32'(f == 10));
    chk("change_n", 32'(change_n), 32'(f == 5));
    chk("coin_rej", 32'(coin_rej), 32'(m_rej));
    chk("credit", 32'(credit), 32'(m_credit));
  endtask

  task automatic tick(input bit n, d, q, c);
    N = n; D = d; Q = q; cancel = c;
    @(posedge clock);
    model_step(n, d, q, c);
    #1;
    N = 0; D = 0; Q = 0; cancel = 0;
    @(negedge clock);
    check_model();
  endtask

  task automatic tick2(input bit n, d, q, c);
    N2 = n; D2 = d; Q2 = q; cancel2 = c;
    @(posedge clock);
    #1;
    N2 = 0; D2 = 0; Q2 = 0; cancel2 = 0;
    @(negedge clock);
  endtask

  initial begin
    int r;
    reset = 1;
    N = 0; D = 0; Q = 0; cancel = 0;
    N2 = 0; D2 = 0; Q2 = 0; cancel2 = 0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    check_model();
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);

    // single quarter vends exactly
    tick(0, 0, 1, 0);
    chk("q_P", 32'(P), 32'd1);
    chk("q_credit", 32'(credit), 32'd0);
    tick(0, 0, 0, 0);
    chk("q_idle_C", 32'(C), 32'd0);

    // D,D,D -> vend with a nickel back
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("ddd_c20", 32'(credit), 32'd20);
    tick(0, 1, 0, 0);
    chk("ddd_c5", 32'(credit), 32'd5);
    tick(0, 0, 0, 0);
    chk("ddd_n", 32'(change_n), 32'd1);
    tick(0, 0, 0, 0);

    // N,D,Q -> vend, dime then nickel
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    chk("ndq_c15", 32'(credit), 32'd15);
    tick(0, 0, 0, 0);
    chk("ndq_d", 32'(change_d), 32'd1);
    tick(0, 0, 0, 0);
    chk("ndq_n", 32'(change_n), 32'd1);
    tick(0, 0, 0, 0);

    // D,D,cancel with a quarter arriving during refund
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 1);
    chk("cancel_d", 32'(change_d), 32'd1);
    tick(0, 0, 1, 0);
    chk("busy_rej", 32'(coin_rej), 32'd1);
    tick(0, 0, 0, 0);

    // simultaneous coins rejected
    tick(0, 1, 1, 0);
    chk("multi_rej", 32'(coin_rej), 32'd1);
    tick(0, 0, 0, 0);

    // reset mid-CHANGE drops outputs without a clock edge
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 1);
    #2 reset = 1;
    #1;
    chk("rst_C", 32'(C), 32'd0);
    chk("rst_chd", 32'(change_d), 32'd0);
    chk("rst_credit", 32'(credit), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 0;
    check_model();

    // overflow on a MAX_CREDIT=30 unit
    tick2(0, 1, 0, 0);
    tick2(0, 1, 0, 0);
    chk("ovf_c20", 32'(credit2), 32'd20);
    tick2(0, 0, 1, 0);
    chk("ovf_rej", 32'(rej2), 32'd1);
    chk("ovf_credit", 32'(credit2), 32'd20);
    chk("ovf_P", 32'(P2), 32'd0);
    tick2(1, 0, 0, 0);
    chk("ovf_vend", 32'(P2), 32'd1);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 15));
      case (r)
        0, 1, 2:    tick(1, 0, 0, 0);
        3, 4, 5:    tick(0, 1, 0, 0);
        6, 7:       tick(0, 0, 1, 0);
        8:          tick(0, 1, 1, 0);
        9:          tick(1, 1, 1, 0);
        10:         tick(0, 0, 0, 1);
        11:         tick(0, 1, 0, 1);
        default:    tick(0, 0, 0, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
